// File: rtl/int_trig_pkg.sv
// Shared types and helpers for the multi-channel internal trigger.
// Edge-detect hit mode is selected by INTTRIG_EDGE_EN.
package int_trig_pkg;

  localparam int NCH_DEF = 2;
  localparam int DW_DEF  = 14;
  localparam int CW_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE,
    FIRE,
    HOLDOFF
  } state_t;

  function automatic logic [3:0] popcount(input logic [7:0] v);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      s = s + {3'b000, v[i]};
    end
    return s;
  endfunction

endpackage

// File: rtl/int_trig_disc.sv
// Per-channel discriminator: threshold compare, mask, optional edge detect.
// INTTRIG_EDGE_EN selects rising-crossing hits instead of level hits.
module int_trig_disc
  import int_trig_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] samp,
  input  logic [DW-1:0] thres,
  input  logic          mask,
  output logic          hit
);

  logic above;

  assign above = (samp >= thres);

`ifdef INTTRIG_EDGE_EN
  logic above_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      above_prev <= 1'b0;
    end else begin
      above_prev <= above;
    end
  end

  assign hit = above & ~above_prev & mask;
`else
  logic unused_clk_rst;

  assign unused_clk_rst = clk ^ rst_n;
  assign hit = above & mask;
`endif

endmodule

// File: rtl/int_trig_mc.sv
// N-of-M coincidence self-trigger with fixed-length pulse and holdoff.
// Build with INTTRIG_EDGE_EN for edge-detect hits.
module int_trig_mc
  import int_trig_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int DW  = DW_DEF,
  parameter int CW  = CW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH*DW-1:0] tdat,
  input  logic              enable,
  input  logic [DW-1:0]     thres,
  input  logic [NCH-1:0]    ch_mask,
  input  logic [3:0]        min_coinc,
  input  logic [CW-1:0]     trg_len,
  input  logic [CW-1:0]     holdoff,
  output logic              otrig,
  output logic [NCH-1:0]    trg_ch,
  output logic [CW-1:0]     trg_cnt,
  output logic              busy
);

  logic [NCH-1:0] hit;
  logic [7:0]     hit8;
  logic [3:0]     nhit;
  logic           fire;
  logic [CW-1:0]  len_eff;
  logic [CW-1:0]  cnt;
  state_t         state;

  for (genvar i = 0; i < NCH; i++) begin : g_disc
    int_trig_disc #(
      .DW(DW)
    ) u_disc (
      .clk  (clk),
      .rst_n(rst_n),
      .samp (tdat[i*DW +: DW]),
      .thres(thres),
      .mask (ch_mask[i]),
      .hit  (hit[i])
    );
  end

  assign hit8    = 8'(hit);
  assign nhit    = popcount(hit8);
  assign fire    = enable & (min_coinc != 4'd0) & (nhit >= min_coinc);
  assign len_eff = (trg_len == '0) ? CW'(1) : trg_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      otrig   <= 1'b0;
      busy    <= 1'b0;
      trg_ch  <= '0;
      trg_cnt <= '0;
    end else if (!enable) begin
      state <= IDLE;
      cnt   <= '0;
      otrig <= 1'b0;
      busy  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (fire) begin
            state  <= FIRE;
            cnt    <= CW'(1);
            otrig  <= 1'b1;
            busy   <= 1'b1;
            trg_ch <= hit;
            if (trg_cnt != '1) begin
              trg_cnt <= trg_cnt + 1'b1;
            end
          end
        end
        FIRE: begin
          if (cnt >= len_eff) begin
            cnt   <= CW'(1);
            otrig <= 1'b0;
            if (holdoff != '0) begin
              state <= HOLDOFF;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLDOFF: begin
          // Exit takes one IDLE cycle before a new fire can be evaluated
          if (cnt >= holdoff) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          otrig <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_trig_mc.sv
// Scoreboard bench for int_trig_mc: a down-counter model predicts outputs.
// Edge-mode expectations apply when INTTRIG_EDGE_EN is defined.
module tb_int_trig_mc;

  typedef struct packed {
    logic        otrig;
    logic        busy;
    logic [1:0]  trg_ch;
    logic [15:0] trg_cnt;
  } out_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [27:0] tdat;
  logic        enable;
  logic [13:0] thres;
  logic [1:0]  ch_mask;
  logic [3:0]  min_coinc;
  logic [15:0] trg_len;
  logic [15:0] holdoff;
  logic        otrig;
  logic [1:0]  trg_ch;
  logic [15:0] trg_cnt;
  logic        busy;

  int errors = 0;
  int checks = 0;

  out_t exp_q[$];
  out_t obs_q[$];

  int          m_hi;
  int          m_lo;
  logic [1:0]  m_ch;
  logic [15:0] m_cnt;
  logic [1:0]  m_prev;

  int_trig_mc #(
    .NCH(2),
    .DW (14),
    .CW (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tdat     (tdat),
    .enable   (enable),
    .thres    (thres),
    .ch_mask  (ch_mask),
    .min_coinc(min_coinc),
    .trg_len  (trg_len),
    .holdoff  (holdoff),
    .otrig    (otrig),
    .trg_ch   (trg_ch),
    .trg_cnt  (trg_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_hi   = 0;
    m_lo   = 0;
    m_ch   = 2'b00;
    m_cnt  = 16'd0;
    m_prev = 2'b00;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic set_d(input int c1, input int c0);
    tdat = {14'(c1), 14'(c0)};
  endtask

  // Predict next-cycle outputs from the current inputs, then clock the DUT.
  task automatic step();
    logic [1:0] above;
    logic [1:0] hit;
    int         nh;
    out_t       e;
    out_t       o;
    above[0] = (tdat[13:0] >= thres);
    above[1] = (tdat[27:14] >= thres);
`ifdef INTTRIG_EDGE_EN
    hit = above & ~m_prev & ch_mask;
`else
    hit = above & ch_mask;
`endif
    m_prev = above;
    nh = int'(hit[0]) + int'(hit[1]);
    if (!enable) begin
      m_hi = 0;
      m_lo = 0;
    end else if (m_hi > 0) begin
      if (m_hi == 1) begin
        m_hi = 0;
        m_lo = int'(holdoff);
      end else begin
        m_hi = m_hi - 1;
      end
    end else if (m_lo > 0) begin
      m_lo = m_lo - 1;
    end else if (min_coinc != 4'd0 && nh >= int'(min_coinc)) begin
      m_hi = (trg_len == 16'd0) ? 1 : int'(trg_len);
      m_ch = hit;
      if (m_cnt != 16'hffff) m_cnt = m_cnt + 16'd1;
    end
    e.otrig   = (m_hi > 0);
    e.busy    = (m_hi > 0) || (m_lo > 0);
    e.trg_ch  = m_ch;
    e.trg_cnt = m_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    o.otrig   = otrig;
    o.busy    = busy;
    o.trg_ch  = trg_ch;
    o.trg_cnt = trg_cnt;
    obs_q.push_back(o);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic idle(input int n);
    set_d(0, 0);
    steps(n);
  endtask

  task automatic test_reset();
    out_t o;
    rst_n     = 1'b0;
    enable    = 1'b1;
    thres     = 14'd100;
    ch_mask   = 2'b11;
    min_coinc = 4'd1;
    trg_len   = 16'd5;
    holdoff   = 16'd0;
    set_d(0, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    o = {otrig, busy, trg_ch, trg_cnt};
    checks++;
    if (o !== 20'd0) begin
      errors++;
      $display("FAIL reset: got %h want 00000", o);
    end
    #3;
    rst_n = 1'b1;
    idle(2);
    while (exp_q.size() > 0) begin
      out_t e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_idle: got %p want %p", o, e);
      end
    end
  endtask

  task automatic test_basic();
    out_t o;
    int   hi_cnt;
    logic [15:0] cnt0;
    cnt0 = m_cnt;
    thres = 14'd100;
    ch_mask = 2'b11;
    min_coinc = 4'd1;
    trg_len = 16'd5;
    holdoff = 16'd0;
    set_d(0, 99);
    steps(3);
    set_d(0, 100);
    step();
    idle(8);
    hi_cnt = 0;
    while (exp_q.size() > 0) begin
      out_t e = exp_q.pop_front();
      o = obs_q.pop_front();
      if (o.otrig) hi_cnt++;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL basic: got %p want %p", o, e);
      end
    end
    checks++;
    if (hi_cnt != 5) begin
      errors++;
      $display("FAIL basic_len: got %0d high cycles want 5", hi_cnt);
    end
    checks++;
    if (trg_ch !== 2'b01 || trg_cnt !== cnt0 + 16'd1) begin
      errors++;
      $display("FAIL basic_ch: got ch=%b cnt=%0d want ch=01 cnt=%0d",
               trg_ch, trg_cnt, cnt0 + 16'd1);
    end
  endtask

  task automatic test_coinc();
    min_coinc = 4'd2;
    trg_len = 16'd2;
    set_d(50, 150);
    steps(6);
    set_d(150, 150);
    step();
    idle(6);
    while (exp_q.size() > 0) begin
      out_t e = exp_q.pop_front();
      out_t o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL coinc: got %p want %p", o, e);
      end
    end
    checks++;
    if (trg_ch !== 2'b11) begin
      errors++;
      $display("FAIL coinc_ch: got %b want 11", trg_ch);
    end
  endtask

  task automatic test_holdoff();
    logic [15:0] cnt0;
    int          want;
    min_coinc = 4'd1;
    trg_len = 16'd3;
    holdoff = 16'd4;
    idle(4);
    cnt0 = m_cnt;
    set_d(200, 200);
    steps(32);
    idle(12);
`ifdef INTTRIG_EDGE_EN
    want = 1;
`else
    want = 4;
`endif
    while (exp_q.size() > 0) begin
      out_t e = exp_q.pop_front();
      out_t o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL holdoff: got %p want %p", o, e);
      end
    end
    checks++;
    if (trg_cnt !== cnt0 + 16'(want)) begin
      errors++;
      $display("FAIL holdoff_cnt: got %0d want %0d", trg_cnt, cnt0 + 16'(want));
    end
  endtask

  task automatic test_enable();
    trg_len = 16'd10;
    holdoff = 16'd0;
    idle(4);
    set_d(200, 200);
    steps(2);
    enable = 1'b0;
    step();
    enable = 1'b1;
    steps(3);
    set_d(0, 0);
    enable = 1'b0;
    step();
    enable = 1'b1;
    idle(3);
    while (exp_q.size() > 0) begin
      out_t e = exp_q.pop_front();
      out_t o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL enable: got %p want %p", o, e);
      end
    end
  endtask

  task automatic test_never();
    logic [15:0] cnt0;
    trg_len = 16'd2;
    idle(2);
    cnt0 = m_cnt;
    ch_mask = 2'b10;
    min_coinc = 4'd1;
    set_d(0, 1000);
    steps(10);
    ch_mask = 2'b11;
    min_coinc = 4'd0;
    idle(2);
    set_d(1000, 1000);
    steps(10);
    min_coinc = 4'd1;
    idle(2);
    while (exp_q.size() > 0) begin
      out_t e = exp_q.pop_front();
      out_t o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL never: got %p want %p", o, e);
      end
    end
    checks++;
    if (trg_cnt !== cnt0) begin
      errors++;
      $display("FAIL never_cnt: got %0d want %0d", trg_cnt, cnt0);
    end
  endtask

`ifdef INTTRIG_EDGE_EN
  task automatic test_edge();
    logic [15:0] cnt0;
    trg_len = 16'd2;
    holdoff = 16'd0;
    idle(4);
    cnt0 = m_cnt;
    set_d(200, 200);
    steps(50);
    idle(3);
    set_d(200, 200);
    steps(5);
    idle(3);
    while (exp_q.size() > 0) begin
      out_t e = exp_q.pop_front();
      out_t o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL edge: got %p want %p", o, e);
      end
    end
    checks++;
    if (trg_cnt !== cnt0 + 16'd2) begin
      errors++;
      $display("FAIL edge_cnt: got %0d want %0d", trg_cnt, cnt0 + 16'd2);
    end
  endtask
`endif

  task automatic test_async_reset();
    trg_len = 16'd5;
    holdoff = 16'd0;
    idle(4);
    set_d(0, 300);
    steps(2);
    while (exp_q.size() > 0) begin
      out_t e = exp_q.pop_front();
      out_t o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL async_pre: got %p want %p", o, e);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (otrig !== 1'b0 || busy !== 1'b0 || trg_cnt !== 16'd0) begin
      errors++;
      $display("FAIL async_rst: got otrig=%b busy=%b cnt=%0d want 0 0 0",
               otrig, busy, trg_cnt);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    set_d(0, 0);
    @(posedge clk);
    #1;
    idle(3);
    while (exp_q.size() > 0) begin
      out_t e = exp_q.pop_front();
      out_t o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL async_post: got %p want %p", o, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_coinc();
    test_holdoff();
    test_enable();
    test_never();
`ifdef INTTRIG_EDGE_EN
    test_edge();
`endif
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/int_trig_mc.md
# int_trig_mc

Multi-channel internal self-trigger for the 2-ADC front end; the next generation of the single-channel threshold trigger. Compares each ADC channel against a runtime threshold and forms an N-of-M coincidence. On a trigger it drives a fixed-length trigger pulse, then applies a programmable holdoff. It sits between the ADC sample registers and the trigger/readout logic, and also reports which channels fired plus a running trigger count.

## Interface
- NCH, 2, number of ADC channels (1..8)
- DW, 14, sample width per channel
- CW, 16, width of pulse-length, holdoff and trigger counters
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  reset, asynchronous, active-low
- tdat  in  NCH*DW  packed samples; channel i at bits [i*DW +: DW], unsigned, valid every cycle
- enable  in  1  arms the trigger; low forces IDLE
- thres  in  DW  common threshold; a channel is above when sample >= thres (unsigned)
- ch_mask  in  NCH  1 = channel participates in coincidence
- min_coinc  in  4  required number of simultaneous hits; 0 = never trigger
- trg_len  in  CW  otrig pulse length in cycles; 0 treated as 1
- holdoff  in  CW  dead cycles after pulse; 0 = none
- otrig  out  1  trigger pulse
- trg_ch  out  NCH  masked hit pattern latched at trigger entry
- trg_cnt  out  CW  number of triggers since reset, saturating
- busy  out  1  high in FIRE or HOLDOFF

## Operation
- Per channel: above_i = tdat_i >= thres; hit_i = above_i & ch_mask[i] (level mode).
- nhit = popcount(hit); fire = enable & (min_coinc != 0) & (nhit >= min_coinc); the comparison is done zero-extended to 4 bits.
- FSM states: IDLE, FIRE, HOLDOFF (encoded in the package).
- IDLE: on fire -> FIRE; latch trg_ch = hit; cnt <= 1; trg_cnt += 1, stopping at all-ones.
- FIRE: otrig = 1. If cnt >= max(trg_len,1): go to HOLDOFF when holdoff != 0, else IDLE; cnt <= 1. Otherwise cnt += 1.
- HOLDOFF: otrig = 0; hits ignored; leave for IDLE when cnt >= holdoff, else cnt += 1.
- Hits during FIRE/HOLDOFF are ignored and do not extend the pulse (no retrigger).
- trg_len and holdoff are compared live. Changing them mid-pulse takes effect at the next comparison.
- thres, ch_mask and min_coinc are sampled every cycle.
- enable low in any state: next cycle state = IDLE, otrig = 0, cnt = 0. trg_ch and trg_cnt are held.

## Timing
- Reset values: otrig 0, busy 0, trg_ch 0, trg_cnt 0, state IDLE, cnt 0, edge history 0.
- Latency: fire at sample cycle t -> otrig high from cycle t+1.
- otrig stays high exactly max(trg_len,1) cycles.
- Pulse is followed by exactly holdoff low cycles during which triggers cannot occur.
- Earliest retrigger: sample at t+1+max(trg_len,1)+holdoff. With holdoff=0, a continuously firing input gives max(trg_len,1) high then 1 low cycle (the IDLE evaluation cycle), repeated.
- busy = (state != IDLE), registered alongside otrig.
- Async reset mid-pulse drops otrig immediately. No other output is combinational.

## Configuration
- INTTRIG_EDGE_EN defined: hit_i = above_i & ~above_prev_i & ch_mask[i]. above_prev_i is registered every cycle in all states, so a channel must drop below threshold and cross again to count. A channel above threshold out of reset produces one hit on its first sample.
- INTTRIG_EDGE_EN undefined: level mode as above; no above_prev registers are built.

## Structure
- Package int_trig_pkg: state enum (IDLE, FIRE, HOLDOFF), default widths, and a popcount function.
- Sub-module int_trig_disc: one per channel via generate. Holds the comparator, mask, and optional edge register. Outputs hit_i.
- Top level: coincidence sum, FSM, counters.

## Test plan
- NCH=2, thres=100, mask=11, min_coinc=1, trg_len=5, holdoff=0; ch0 sample 99 then 100 at t -> otrig high t+1..t+5, trg_ch=01, trg_cnt=1.
- min_coinc=2; ch0=150, ch1=50 -> no trigger; then both 150 at t -> otrig at t+1, trg_ch=11.
- trg_len=3, holdoff=4, input held at 200 -> otrig pattern 3 high / 5 low repeating; trg_cnt increments once per pulse.
- enable dropped mid-FIRE at cycle 2 of 10 -> otrig 0 next cycle, busy 0; re-enable with input high -> new pulse starts 1 cycle later.
- mask=10, ch0=1000, ch1=0 -> never triggers; min_coinc=0 with all channels high -> never triggers.
- INTTRIG_EDGE_EN, input held at 200 for 50 cycles, trg_len=2, holdoff=0 -> exactly one trigger; drop to 0 and raise to 200 -> second trigger.
